irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter TW, default 32, meaning timer counter and compare width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tcmp  input  TW  new timer compare value, taken from the x4 (TCMP) write data.
REQ-005 SHALL have port tcmp_we  input  1  one-cycle pulse that loads tcmp and restarts the timer.
REQ-006 SHALL have port key_valid  input  1  one-cycle pulse when the UART receiver delivers a keyboard byte.
REQ-007 SHALL have ports ien, idis, iack  input  1 each  one-cycle pulses from CPU decode of IEN, IDIS and IACK.
REQ-008 SHALL have port irq  output  1  registered interrupt request level to the CPU.
REQ-009 SHALL have port irq_cause  output  2  registered cause: 0 none, 1 timer, 2 keyboard; 3 never driven.
REQ-010 SHALL have port int_enabled  output  1  high in states ENABLED and SERVICE.
REQ-011 SHALL have port timer_count  output  TW  current timer counter value.

Function
REQ-012 SHALL hold a compare register cmp_q; tcmp_we loads cmp_q<=tcmp and timer_count<=0, and no timer match is taken in that cycle.
REQ-013 SHALL hold timer_count at 0 and never raise a timer event while cmp_q==0.
REQ-014 SHALL, with cmp_q!=0, increment timer_count by 1 each cycle; when timer_count==cmp_q-1, the next value SHALL be 0 and a one-cycle timer event SHALL fire (period exactly cmp_q cycles).
REQ-015 SHALL keep sticky pending bits pend_t and pend_k, set by the timer event and key_valid respectively; repeated events collapse into one bit.
REQ-016 SHALL set pending bits in every state, including DISABLED and SERVICE.
REQ-017 SHALL implement states DISABLED, ENABLED and SERVICE; reset enters DISABLED.
REQ-018 DISABLED: ien -> ENABLED; all other inputs leave the state unchanged.
REQ-019 ENABLED: idis -> DISABLED (idis has priority); else, if pend_t or pend_k is set -> SERVICE, capturing cause with timer priority over keyboard.
REQ-020 SERVICE: irq=1 and irq_cause SHALL hold the captured cause; ien is ignored.
REQ-021 SERVICE: iack SHALL clear the captured cause's pending bit and go to ENABLED; idis SHALL go to DISABLED with pending bits kept; if both occur, iack clears the bit and the next state is DISABLED.
REQ-022 SHALL let a set win over a clear when an event and an iack clear the same pending bit in the same cycle.
REQ-023 SHALL make latency from an event edge to irq=1 exactly 2 cycles in ENABLED: the pending bit is set at edge N+1 and SERVICE/irq is registered at edge N+2.
REQ-024 SHALL drive irq=0 and irq_cause=0 in DISABLED and ENABLED.
REQ-025 SHALL let SERVICE be re-entered back-to-back: after iack, if the other bit is still pending, the next ENABLED cycle SHALL enter SERVICE.

Reset
REQ-026 SHALL, on reset, set state=DISABLED, irq=0, irq_cause=0, int_enabled=0, timer_count=0, cmp_q=0, pend_t=0 and pend_k=0.
REQ-027 SHALL give reset priority over every other input, including reset asserted mid-SERVICE; the outputs above SHALL appear in the first cycle after the reset edge.

Structure
REQ-028 SHALL define the IRQ_STATE enum (DISABLED, ENABLED, SERVICE) and the IRQ_CAUSE enum (NONE=0, TIMER=1, KEY=2) in package lib_cpu.
REQ-029 SHALL implement the counter and compare logic of REQ-012 to REQ-014 as sub-module irq_timer, with outputs timer_count and a timer event pulse.

Verification
REQ-030 SHALL test: tcmp=5 with tcmp_we at cycle 0 -> timer event every 5 cycles; timer_count sequence 0,1,2,3,4,0.
REQ-031 SHALL test: ien, then key_valid at edge N -> irq=1 with irq_cause=2 at N+2; iack -> irq=0, state ENABLED, pend_k=0.
REQ-032 SHALL test: timer event and key_valid in the same cycle while ENABLED -> cause 1 serviced first; after iack, cause 2 in SERVICE two cycles later.
REQ-033 SHALL test: key_valid while DISABLED -> irq stays 0; ien 10 cycles later -> irq=1 with cause 2 two cycles after ien.
REQ-034 SHALL test: in SERVICE (cause 2), key_valid coincident with iack -> pend_k stays 1 and SERVICE is re-entered with cause 2.
REQ-035 SHALL test: reset asserted mid-SERVICE with tcmp=3 -> all outputs 0 next cycle, timer stopped (cmp_q=0), ien gives no irq.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared CPU-side types for the interrupt controller: controller states and
// interrupt cause codes as seen on irq_cause.
package lib_cpu;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ENABLED  = 2'd1,
        SERVICE  = 2'd2
    } irq_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        TIMER = 2'd1,
        KEY   = 2'd2
    } irq_cause_t;

endpackage

// File: rtl/irq_ctrl_timer.sv
// Periodic timer: counts 0..cmp_q-1 and pulses timer_event on the last count.
// A zero compare value parks the counter at 0.
module irq_timer #(
    parameter int unsigned TW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] tcmp,
    input  logic          tcmp_we,
    output logic [TW-1:0] timer_count,
    output logic          timer_event
);

    logic [TW-1:0] cmp_q;

    // A compare load restarts the period, so it suppresses the match in that cycle.
    assign timer_event = !tcmp_we && (cmp_q != '0) && (timer_count == cmp_q - TW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q       <= '0;
            timer_count <= '0;
        end else if (tcmp_we) begin
            cmp_q       <= tcmp;
            timer_count <= '0;
        end else if ((cmp_q == '0) || timer_event) begin
            timer_count <= '0;
        end else begin
            timer_count <= timer_count + TW'(1);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sticky timer/keyboard pending bits feeding a
// DISABLED/ENABLED/SERVICE state machine with registered irq outputs.
module irq_ctrl
    import lib_cpu::*;
#(
    parameter int unsigned TW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] tcmp,
    input  logic          tcmp_we,
    input  logic          key_valid,
    input  logic          ien,
    input  logic          idis,
    input  logic          iack,
    output logic          irq,
    output logic [1:0]    irq_cause,
    output logic          int_enabled,
    output logic [TW-1:0] timer_count
);

    irq_state_t state_q, state_d;
    irq_cause_t cap_q, cap_d;
    logic       pend_t_q, pend_k_q;
    logic       clr_t, clr_k;
    logic       timer_event;

    irq_timer #(.TW(TW)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .tcmp        (tcmp),
        .tcmp_we     (tcmp_we),
        .timer_count (timer_count),
        .timer_event (timer_event)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        clr_t   = 1'b0;
        clr_k   = 1'b0;
        unique case (state_q)
            DISABLED: begin
                if (ien) state_d = ENABLED;
            end
            ENABLED: begin
                if (idis) begin
                    state_d = DISABLED;
                end else if (pend_t_q) begin
                    state_d = SERVICE;
                    cap_d   = TIMER;
                end else if (pend_k_q) begin
                    state_d = SERVICE;
                    cap_d   = KEY;
                end
            end
            SERVICE: begin
                // iack always clears its bit; idis then overrides the destination.
                if (iack) begin
                    clr_t   = (cap_q == TIMER);
                    clr_k   = (cap_q == KEY);
                    state_d = ENABLED;
                end
                if (idis) state_d = DISABLED;
            end
            default: state_d = DISABLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DISABLED;
            cap_q       <= NONE;
            pend_t_q    <= 1'b0;
            pend_k_q    <= 1'b0;
            irq         <= 1'b0;
            irq_cause   <= NONE;
            int_enabled <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            // A new event wins over a same-cycle acknowledge.
            pend_t_q    <= timer_event | (pend_t_q & ~clr_t);
            pend_k_q    <= key_valid   | (pend_k_q & ~clr_k);
            irq         <= (state_d == SERVICE);
            irq_cause   <= (state_d == SERVICE) ? cap_d : NONE;
            int_enabled <= (state_d != DISABLED);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a cycle-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_irq_ctrl;

    localparam int unsigned TW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [TW-1:0] tcmp;
    logic          tcmp_we, key_valid, ien, idis, iack;
    logic          irq;
    logic [1:0]    irq_cause;
    logic          int_enabled;
    logic [TW-1:0] timer_count;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    irq_ctrl #(.TW(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .tcmp        (tcmp),
        .tcmp_we     (tcmp_we),
        .key_valid   (key_valid),
        .ien         (ien),
        .idis        (idis),
        .iack        (iack),
        .irq         (irq),
        .irq_cause   (irq_cause),
        .int_enabled (int_enabled),
        .timer_count (timer_count)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = interrupts off, 1 = on and idle, 2 = servicing.
    // Timer position is derived from the number of cycles since the last compare load.
    int          m_mode   = 0;
    int          m_cause  = 0;
    bit          m_pt     = 1'b0;
    bit          m_pk     = 1'b0;
    int unsigned m_period = 0;
    int unsigned m_age    = 0;

    always @(posedge clk) begin : model
        bit fire, acked, leave_off;
        if (reset) begin
            m_mode   <= 0;
            m_cause  <= 0;
            m_pt     <= 1'b0;
            m_pk     <= 1'b0;
            m_period <= 0;
            m_age    <= 0;
        end else begin
            fire  = !tcmp_we && m_period != 0 && (m_age % m_period) == m_period - 1;
            acked = (m_mode == 2) && iack;
            m_pt <= fire      || (m_pt && !(acked && m_cause == 1));
            m_pk <= key_valid || (m_pk && !(acked && m_cause == 2));
            leave_off = 1'b0;
            if (m_mode == 0) begin
                if (ien) m_mode <= 1;
            end else if (m_mode == 1) begin
                if (idis) m_mode <= 0;
                else if (m_pt || m_pk) begin
                    m_mode  <= 2;
                    m_cause <= m_pt ? 1 : 2;
                end
            end else begin
                if (idis) m_mode <= 0;
                else if (iack) m_mode <= 1;
            end
            if (tcmp_we) begin
                m_period <= tcmp;
                m_age    <= 0;
            end else if (m_period != 0) begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_irq",         irq,         (m_mode == 2) ? 1 : 0);
            check("model_irq_cause",   irq_cause,   (m_mode == 2) ? m_cause : 0);
            check("model_int_enabled", int_enabled, (m_mode != 0) ? 1 : 0);
            check("model_timer_count", timer_count, (m_period == 0) ? 0 : (m_age % m_period));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tcmp = '0; tcmp_we = 0; key_valid = 0; ien = 0; idis = 0; iack = 0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_irq", irq, 0);
        check("reset_cause", irq_cause, 0);
        check("reset_en", int_enabled, 0);
        check("reset_count", timer_count, 0);
        chk_en = 1'b1;

        // Period-5 timer.
        tcmp = 5; tcmp_we = 1; tick(); tcmp_we = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t1_count", timer_count, i % 5);
            tick();
        end
        reset_pulse();

        // Keyboard interrupt, two-cycle latency, acknowledge.
        ien = 1; tick(); ien = 0;
        @(negedge clk); check("t2_enabled", int_enabled, 1);
        key_valid = 1; tick(); key_valid = 0;
        @(negedge clk); check("t2_irq_early", irq, 0);
        tick();
        @(negedge clk); check("t2_irq", irq, 1); check("t2_cause", irq_cause, 2);
        iack = 1; tick(); iack = 0;
        @(negedge clk); check("t2_ack_irq", irq, 0); check("t2_ack_en", int_enabled, 1);
        tick(); tick();
        @(negedge clk); check("t2_no_repeat", irq, 0);
        reset_pulse();

        // Simultaneous timer and key events: timer serviced first.
        ien = 1; tcmp = 4; tcmp_we = 1; tick(); ien = 0; tcmp_we = 0;
        tick(); tick(); tick();
        key_valid = 1; tick(); key_valid = 0;
        @(negedge clk); check("t3_irq_early", irq, 0);
        tick();
        @(negedge clk); check("t3_irq", irq, 1); check("t3_cause_timer", irq_cause, 1);
        iack = 1; tick(); iack = 0;
        @(negedge clk); check("t3_gap", irq, 0);
        tick();
        @(negedge clk); check("t3_irq2", irq, 1); check("t3_cause_key", irq_cause, 2);
        reset_pulse();

        // Key pending while disabled, serviced once enabled.
        key_valid = 1; tick(); key_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); check("t4_disabled_irq", irq, 0);
            tick();
        end
        ien = 1; tick(); ien = 0;
        @(negedge clk); check("t4_irq_early", irq, 0);
        tick();
        @(negedge clk); check("t4_irq", irq, 1); check("t4_cause", irq_cause, 2);

        // Key event coincident with iack re-arms the same cause.
        key_valid = 1; iack = 1; tick(); key_valid = 0; iack = 0;
        @(negedge clk); check("t5_gap", irq, 0); check("t5_en", int_enabled, 1);
        tick();
        @(negedge clk); check("t5_irq", irq, 1); check("t5_cause", irq_cause, 2);
        idis = 1; tick(); idis = 0;
        @(negedge clk); check("t5_idis_irq", irq, 0); check("t5_idis_en", int_enabled, 0);
        ien = 1; tick(); ien = 0; tick();
        @(negedge clk); check("t5_kept_irq", irq, 1); check("t5_kept_cause", irq_cause, 2);
        iack = 1; idis = 1; tick(); iack = 0; idis = 0;
        @(negedge clk); check("t5_both_en", int_enabled, 0);
        ien = 1; tick(); ien = 0; tick();
        @(negedge clk); check("t5_cleared", irq, 0);
        reset_pulse();

        // Reset in the middle of a timer service.
        tcmp = 3; tcmp_we = 1; ien = 1; tick(); tcmp_we = 0; ien = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (irq) break;
            tick();
        end
        check("t6_irq_reached", irq, 1);
        check("t6_cause", irq_cause, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        @(negedge clk);
        check("t6_rst_irq", irq, 0);
        check("t6_rst_cause", irq_cause, 0);
        check("t6_rst_en", int_enabled, 0);
        check("t6_rst_count", timer_count, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk); check("t6_timer_stopped", timer_count, 0);
        end
        ien = 1; tick(); ien = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); check("t6_no_irq", irq, 0);
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
